// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between a fetch and a data requester, with data priority and access timeout.
// Optional MEM_ARBITER_PERF_EN adds a saturating conflict_cnt output.
module mem_arbiter #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] i_rdata,
    output logic        i_valid,
    output logic [15:0] d_rdata,
    output logic        d_valid,
    output logic        i_stall,
    output logic        d_stall,
`ifdef MEM_ARBITER_PERF_EN
    output logic [15:0] conflict_cnt,
`endif
    output logic        err
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, D_ACC, I_ACC, ERR} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;
    logic          en_reg, en_next;
    logic          wr_reg, wr_next;
    logic [15:0]   addr_reg, addr_next;
    logic [15:0]   wdata_reg, wdata_next;
    logic [15:0]   irdata_reg, irdata_next;
    logic [15:0]   drdata_reg, drdata_next;
    logic          ivalid_reg, ivalid_next;
    logic          dvalid_reg, dvalid_next;
    logic          err_reg;
    logic          i_elig, d_elig;

    // A requester whose completion pulse is showing is still holding its old request.
    assign i_elig  = i_req && !ivalid_reg;
    assign d_elig  = d_req && !dvalid_reg;
    assign cnt_inc = cnt_reg + 1'b1;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        en_next     = en_reg;
        wr_next     = wr_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        irdata_next = irdata_reg;
        drdata_next = drdata_reg;
        ivalid_next = 1'b0;
        dvalid_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (d_elig) begin
                    state_next = D_ACC;
                    cnt_next   = '0;
                    en_next    = 1'b1;
                    wr_next    = d_wr;
                    addr_next  = d_addr;
                    wdata_next = d_wdata;
                end else if (i_elig) begin
                    state_next = I_ACC;
                    cnt_next   = '0;
                    en_next    = 1'b1;
                    wr_next    = 1'b0;
                    addr_next  = i_addr;
                end
            end
            D_ACC, I_ACC: begin
                if (mem_done) begin
                    state_next = IDLE;
                    en_next    = 1'b0;
                    if (state_reg == I_ACC) begin
                        ivalid_next = 1'b1;
                        irdata_next = mem_rdata;
                    end else begin
                        dvalid_next = 1'b1;
                        if (!wr_reg)
                            drdata_next = mem_rdata;
                    end
                end else begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == CW'(TIMEOUT_CYC)) begin
                        state_next = ERR;
                        en_next    = 1'b0;
                    end
                end
            end
            default: begin
                en_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            en_reg     <= 1'b0;
            wr_reg     <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            irdata_reg <= '0;
            drdata_reg <= '0;
            ivalid_reg <= 1'b0;
            dvalid_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            en_reg     <= en_next;
            wr_reg     <= wr_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            irdata_reg <= irdata_next;
            drdata_reg <= drdata_next;
            ivalid_reg <= ivalid_next;
            dvalid_reg <= dvalid_next;
            err_reg    <= (state_next == ERR);
        end
    end

`ifdef MEM_ARBITER_PERF_EN
    logic [15:0] conflict_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            conflict_reg <= '0;
        else if (state_reg == IDLE && i_elig && d_elig && conflict_reg != 16'hFFFF)
            conflict_reg <= conflict_reg + 16'd1;
    end

    assign conflict_cnt = conflict_reg;
`endif

    assign mem_en    = en_reg;
    assign mem_wr    = wr_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign i_rdata   = irdata_reg;
    assign d_rdata   = drdata_reg;
    assign i_valid   = ivalid_reg;
    assign d_valid   = dvalid_reg;
    assign err       = err_reg;
    assign i_stall   = i_req && !ivalid_reg;
    assign d_stall   = d_req && !dvalid_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, conflict, write, timeout and reset-mid-access scenarios.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wr, mem_done;
    logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        mem_en, mem_wr, i_valid, d_valid, i_stall, d_stall, err;
    logic [15:0] mem_addr, mem_wdata, i_rdata, d_rdata;
`ifdef MEM_ARBITER_PERF_EN
    logic [15:0] conflict_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .i_rdata(i_rdata), .i_valid(i_valid), .d_rdata(d_rdata), .d_valid(d_valid),
        .i_stall(i_stall), .d_stall(d_stall),
`ifdef MEM_ARBITER_PERF_EN
        .conflict_cnt(conflict_cnt),
`endif
        .err(err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end else begin
            $display("ok   %s = %h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; i_req = 0; d_req = 0; d_wr = 0; mem_done = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
        tick();
        check("rst_mem_en", mem_en, 0);
        check("rst_err", err, 0);
        check("rst_ivalid", i_valid, 0);
        check("rst_drdata", d_rdata, 0);
        rst = 1'b0;

        // mem_done in IDLE is ignored
        mem_done = 1; mem_rdata = 16'hDEAD;
        tick();
        check("idle_done_en", mem_en, 0);
        check("idle_done_iv", i_valid, 0);
        check("idle_done_irdata", i_rdata, 0);
        mem_done = 0;

        // fetch only
        i_req = 1; i_addr = 16'h0040;
        #1 check("f_istall", i_stall, 1);
        tick();
        check("f_en", mem_en, 1);
        check("f_addr", mem_addr, 16'h0040);
        check("f_wr", mem_wr, 0);
        mem_done = 1; mem_rdata = 16'hA5C3;
        tick();
        check("f_en_off", mem_en, 0);
        check("f_ivalid", i_valid, 1);
        check("f_irdata", i_rdata, 16'hA5C3);
        check("f_istall_off", i_stall, 0);
        i_req = 0; mem_done = 0;
        tick();
        check("f_ivalid_pulse", i_valid, 0);
        check("f_no_reissue", mem_en, 0);

        // conflict: data first
        i_req = 1; i_addr = 16'h0050; d_req = 1; d_wr = 0; d_addr = 16'h0100;
        tick();
        check("c_en", mem_en, 1);
        check("c_addr_d", mem_addr, 16'h0100);
        check("c_istall", i_stall, 1);
`ifdef MEM_ARBITER_PERF_EN
        check("c_cnt", conflict_cnt, 1);
`endif
        mem_done = 1; mem_rdata = 16'hBEEF;
        tick();
        check("c_dvalid", d_valid, 1);
        check("c_drdata", d_rdata, 16'hBEEF);
        check("c_istall2", i_stall, 1);
        check("c_ivalid0", i_valid, 0);
        d_req = 0; mem_done = 0;
        tick();
        check("c_i_en", mem_en, 1);
        check("c_i_addr", mem_addr, 16'h0050);
        mem_done = 1; mem_rdata = 16'h1111;
        tick();
        check("c_ivalid", i_valid, 1);
        check("c_irdata", i_rdata, 16'h1111);
        check("c_drdata_keep", d_rdata, 16'hBEEF);
`ifdef MEM_ARBITER_PERF_EN
        check("c_cnt_final", conflict_cnt, 1);
`endif
        i_req = 0; mem_done = 0;
        tick();

        // write, done in third access cycle
        d_req = 1; d_wr = 1; d_addr = 16'h0200; d_wdata = 16'h1234; mem_rdata = 16'h7777;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("w_en%0d", k), mem_en, 1);
            check($sformatf("w_wr%0d", k), mem_wr, 1);
            check($sformatf("w_wdata%0d", k), mem_wdata, 16'h1234);
            check($sformatf("w_addr%0d", k), mem_addr, 16'h0200);
        end
        mem_done = 1;
        tick();
        check("w_dvalid", d_valid, 1);
        check("w_drdata_keep", d_rdata, 16'hBEEF);
        check("w_en_off", mem_en, 0);
        d_req = 0; d_wr = 0; mem_done = 0;
        tick();
        check("w_dvalid_pulse", d_valid, 0);

        // timeout
        i_req = 1; i_addr = 16'h0060;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("t_en%0d", k), mem_en, 1);
            check($sformatf("t_err%0d", k), err, 0);
        end
        tick();
        check("t_err", err, 1);
        check("t_en_off", mem_en, 0);
        check("t_istall", i_stall, 1);
        mem_done = 1; mem_rdata = 16'h5555;
        tick();
        check("t_done_ign_iv", i_valid, 0);
        check("t_done_ign_err", err, 1);
        check("t_done_ign_rd", i_rdata, 16'h1111);
        mem_done = 0; i_req = 0;
        #2 rst = 1;
        #1 check("t_rst_err", err, 0);
        tick();
        rst = 0;

        // reset mid-access
        d_req = 1; d_wr = 0; d_addr = 16'h0300;
        tick();
        check("r_en1", mem_en, 1);
        tick();
        check("r_en2", mem_en, 1);
        #2 rst = 1;
        #1;
        check("r_en_rst", mem_en, 0);
        check("r_addr_rst", mem_addr, 0);
        check("r_drdata_rst", d_rdata, 0);
        tick();
        rst = 0;
        tick();
        check("r_regrant_en", mem_en, 1);
        check("r_regrant_addr", mem_addr, 16'h0300);
        mem_done = 1; mem_rdata = 16'h4242;
        tick();
        check("r_dvalid", d_valid, 1);
        check("r_drdata", d_rdata, 16'h4242);
        d_req = 0; mem_done = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
